// File: rtl/adc_if_pkg.sv
// -----------------------------------------------------------------------------
// adc_if_pkg
// Constants and types shared by the ADC serial interface blocks: the
// reader (adc_serial_reader) and the control-word writer on TFSnot.
//   ADC_FRAME_BITS : default number of bits in one converter frame
//   ADC_SCLK_IDLE  : level SCLK rests at between frames
//   adc_state_e    : frame sequencing states common to reader and writer
// -----------------------------------------------------------------------------
package adc_if_pkg;

  localparam int   ADC_FRAME_BITS = 16;
  localparam logic ADC_SCLK_IDLE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// -----------------------------------------------------------------------------
// adc_sclk_gen
// Half-period divider producing SCLK for the ADC serial port.
// While en=1, SCLK toggles every CLK_DIV clk cycles, starting from the idle
// level. While en=0, SCLK is held at the idle level and the divider is cleared,
// so each enable period begins with a full idle-level half period.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   en         : run the divider
//   sclk       : serial clock (registered)
//   fall_tick  : high in the clk cycle that drives SCLK 1->0
//   rise_tick  : high in the clk cycle that drives SCLK 0->1
// -----------------------------------------------------------------------------
module adc_sclk_gen
  import adc_if_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int            DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          half_end;

  assign half_end  = en && (div_q == DIV_LAST);
  assign fall_tick = half_end && sclk_q;
  assign rise_tick = half_end && !sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = ADC_SCLK_IDLE;
    end else if (half_end) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DIV_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= ADC_SCLK_IDLE;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// -----------------------------------------------------------------------------
// adc_serial_reader
// Reads one conversion word from the external ADC per start request.
// Drives SCLK / RFSnot, shifts SDATA in MSB-first on SCLK falling edges and
// presents the low DATA_BITS as the sample and the upper bits as status.
// Build option:
//   ADC_READ_SIGNEXT_EN : when defined, the sample field is two's complement
//                         and data_out is sign-extended to 16 bits; otherwise
//                         it is zero-extended. Timing is unaffected.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   start       : one-cycle read request, ignored while busy
//   SDATA       : serial data from ADC (asynchronous, synchronized here)
//   SCLK        : serial clock to ADC, idles high
//   RFSnot      : receive frame sync, active low for the whole frame
//   busy        : frame in progress (SETUP, SHIFT, DONE)
//   data_out    : last sample, held until the next frame completes
//   status_out  : upper frame bits of the last word
//   data_valid  : one-cycle pulse when data_out/status_out update
// -----------------------------------------------------------------------------
module adc_serial_reader
  import adc_if_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int DATA_BITS  = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             SDATA,
  output logic                             SCLK,
  output logic                             RFSnot,
  output logic                             busy,
  output logic [15:0]                      data_out,
  output logic [FRAME_BITS-DATA_BITS-1:0]  status_out,
  output logic                             data_valid
);

  localparam int            CW       = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  adc_state_e                      state_q, state_d;
  logic [CW-1:0]                   bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]           shift_q, shift_d;
  logic [1:0]                      sync_q, sync_d;
  logic [15:0]                     data_q, data_d;
  logic [FRAME_BITS-DATA_BITS-1:0] status_q, status_d;

  logic sclk_en;
  logic fall_tick;
  logic rise_tick;

  function automatic logic [15:0] extend_sample(input logic [DATA_BITS-1:0] raw);
`ifdef ADC_READ_SIGNEXT_EN
    logic signed [DATA_BITS-1:0] sraw;
    sraw = signed'(raw);
    return 16'(sraw);
`else
    return 16'(raw);
`endif
  endfunction

  // SCLK runs only while the frame is being clocked out of the converter.
  assign sclk_en = (state_q == SETUP) || (state_q == SHIFT);

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (sclk_en),
    .sclk      (SCLK),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  assign RFSnot     = !sclk_en;
  assign busy       = (state_q != IDLE);
  assign data_valid = (state_q == DONE);
  assign data_out   = data_q;
  assign status_out = status_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    status_d  = status_q;
    sync_d    = {sync_q[0], SDATA};

    // Synchronized SDATA is sampled in the cycle that drives SCLK low.
    if (sclk_en && fall_tick) begin
      shift_d   = {shift_q[FRAME_BITS-2:0], sync_q[1]};
      bit_cnt_d = bit_cnt_q + CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      SETUP: begin
        if (fall_tick) state_d = SHIFT;
      end
      SHIFT: begin
        // The rise after the final low half-period closes the frame; SCLK and
        // RFSnot return high together as the state leaves SHIFT.
        if (rise_tick && (bit_cnt_q == LAST_BIT)) begin
          state_d  = DONE;
          data_d   = extend_sample(shift_q[DATA_BITS-1:0]);
          status_d = shift_q[FRAME_BITS-1:DATA_BITS];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sync_q    <= '0;
      data_q    <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sync_q    <= sync_d;
      data_q    <= data_d;
      status_q  <= status_d;
    end
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Receive-side serial engine for the external ADC: clocks one conversion word out of the converter and presents it as a parallel sample.
- Drives SCLK and RFSnot (receive frame sync, active low) and shifts in SDATA MSB-first, sampling on SCLK falling edges.
- Sits between the ADC pins and the fetal-ECG sample pipeline, alongside the control-word writer that uses TFSnot on the same interface.

Parameters:
- CLK_DIV, 4: system clk cycles per SCLK half-period; must be >= 3.
- FRAME_BITS, 16: SCLK falling edges, and therefore bits shifted in, per frame.
- DATA_BITS, 12: number of LSBs of the frame that carry the sample; upper bits are status.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to read one word; ignored while busy=1.
- SDATA  input  1  serial data from ADC, asynchronous to clk.
- SCLK  output  1  serial clock to ADC; idles high.
- RFSnot  output  1  receive frame sync, active low.
- busy  output  1  high from the cycle after an accepted start until the cycle after data_valid.
- data_out  output  16  last received sample, held until the next frame completes.
- status_out  output  FRAME_BITS-DATA_BITS  upper frame bits of the last received word.
- data_valid  output  1  one-cycle pulse when data_out/status_out update.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: SCLK=1, RFSnot=1, busy=0, data_valid=0, data_out=0, status_out=0; state IDLE; counters and shift register 0.
- SDATA passes through a 2-flop synchronizer before use. Bits are sampled in the clk cycle that drives SCLK 1->0.
- IDLE: on start=1, go to SETUP; RFSnot=0, busy=1, divider=0.
- SETUP: SCLK held high for CLK_DIV cycles. The last cycle drives SCLK low and samples bit FRAME_BITS-1; go to SHIFT.
- SHIFT: SCLK toggles every CLK_DIV cycles, and each 1->0 transition samples the next bit MSB-first. After FRAME_BITS samples, hold SCLK low CLK_DIV cycles, then drive SCLK=1 and RFSnot=1; go to DONE.
- DONE: a single cycle. data_out gets the low DATA_BITS bits zero-extended, status_out gets the upper bits, and data_valid=1. Go to IDLE with busy=0.
- Latency: data_valid asserts 2*FRAME_BITS*CLK_DIV+1 cycles after the start cycle (129 at defaults). Frame length: RFSnot is low for 2*FRAME_BITS*CLK_DIV cycles.
- start while busy (including the DONE cycle) is dropped, not queued.
- If start is held high, frames run back-to-back with exactly one IDLE cycle between them (RFSnot high, SCLK high).
- rst mid-frame aborts the frame in the next cycle: all outputs return to reset values, and partial data is discarded and never presented.
- data_out/status_out change only in DONE or on reset.

Optional Feature:
- ADC_READ_SIGNEXT_EN
- Defined: the DATA_BITS field is two's complement; data_out is sign-extended from bit DATA_BITS-1 to 16 bits.
- Undefined: data_out is zero-extended.
- Timing is identical in both cases.

Decomposition:
- Package adc_if_pkg holds:
  - the FRAME_BITS default and the SCLK idle level constant;
  - the state enum {IDLE, SETUP, SHIFT, DONE}, shared with the control-word writer.
- Sub-module adc_sclk_gen: CLK_DIV half-period divider with enable. It outputs SCLK plus one-cycle fall_tick/rise_tick strobes; the reader FSM samples on fall_tick.

Test Plan:
- Defaults, ADC model drives 0xA5C3 MSB-first, changing after each SCLK rise -> data_valid at cycle 129 after start, data_out=0x05C3, status_out=0xA, RFSnot low exactly 128 cycles, 16 SCLK falls.
- start pulsed at cycles 10 and 60 -> one frame only, second start ignored, busy high throughout.
- start held high, words 0x1234 then 0xFFFF -> two data_valid pulses 130 cycles apart, one IDLE cycle between frames, outputs 0x0234/0x1 then 0x0FFF/0xF.
- rst asserted for one cycle at SHIFT bit 7 -> next cycle SCLK=1, RFSnot=1, busy=0, data_out=0, no data_valid. A following start yields a clean full frame.
- ADC_READ_SIGNEXT_EN defined, word 0x0800 -> data_out=0xF800. Undefined, same word -> 0x0800.
- CLK_DIV=3, word 0x8001 -> correct capture through the synchronizer, data_valid at cycle 97.
